matrix_stream_loader: RTL and testbench



---
 rtl/matrix_pkg.sv | 27 ++
 rtl/matrix_stream_loader_if.sv | 22 ++
 rtl/mat_load_ctrl.sv | 79 +++++++
 rtl/matrix_stream_loader.sv | 81 ++++++++
 tb/tb_matrix_stream_loader.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, loader state enum and flat-matrix index helpers for the
// 5x5 matrix loader and the inversion stage.
package matrix_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned N        = 5;
    localparam int unsigned NUM_ELEM = N * N;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned MAT_W    = NUM_ELEM * DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } load_state_e;

    // Row-major flat element index.
    function automatic logic [CNT_W-1:0] elem_idx(input logic [CNT_W-1:0] row,
                                                  input logic [CNT_W-1:0] col);
        return CNT_W'(row * CNT_W'(N) + col);
    endfunction

    function automatic logic is_diag(input logic [CNT_W-1:0] k);
        return (k % CNT_W'(N + 1)) == '0;
    endfunction

endpackage

// File: rtl/matrix_stream_loader_if.sv
// Element stream in, assembled matrix out; the loader is the slave side.
interface matrix_stream_loader_if;
    import matrix_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [MAT_W-1:0]  mat_data;
    logic              mat_valid;
    logic              mat_ready;

    modport master (
        output in_data, in_valid, mat_ready,
        input  in_ready, mat_data, mat_valid
    );

    modport slave (
        input  in_data, in_valid, mat_ready,
        output in_ready, mat_data, mat_valid
    );

endinterface

// File: rtl/mat_load_ctrl.sv
// Loader FSM: element counter, stream/handoff handshake decode, and the
// write strobe + slot index for the matrix register array.
module mat_load_ctrl
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             mat_ready,
    output logic             in_ready,
    output logic             mat_valid,
    output logic [CNT_W-1:0] load_count,
    output logic             wr_en_c,
    output logic [CNT_W-1:0] wr_idx_c,
    output logic             clear_c
);

    load_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             mat_valid_q, mat_valid_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            mat_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            mat_valid_q <= mat_valid_d;
        end
    end

    // Flush overrides everything, including a handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en_c = 1'b0;
        clear_c = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            clear_c = 1'b1;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (in_valid) begin
                        wr_en_c = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = (cnt_q == CNT_W'(NUM_ELEM - 1)) ? FULL : LOAD;
                    end
                end
                FULL: begin
                    if (mat_ready) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        clear_c = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        in_ready_d  = (state_d != FULL);
        mat_valid_d = (state_d == FULL);
    end

    assign wr_idx_c   = cnt_q;
    assign in_ready   = in_ready_q;
    assign mat_valid  = mat_valid_q;
    assign load_count = cnt_q;

endmodule

// File: rtl/matrix_stream_loader.sv
// Assembles a row-major element stream into a flat 5x5 matrix for the inversion
// stage. Optional diagonal-zero screen under macro DIAG_ZERO_CHECK_EN.
module matrix_stream_loader
    import matrix_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    matrix_stream_loader_if.slave  s,
    output logic [CNT_W-1:0]       load_count
`ifdef DIAG_ZERO_CHECK_EN
    ,
    output logic                   diag_zero
`endif
);

    logic             wr_en_c;
    logic [CNT_W-1:0] wr_idx_c;
    logic             clear_c;
    logic [DATA_W-1:0] mat_q [NUM_ELEM];

    mat_load_ctrl u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (s.in_valid),
        .mat_ready  (s.mat_ready),
        .in_ready   (s.in_ready),
        .mat_valid  (s.mat_valid),
        .load_count (load_count),
        .wr_en_c    (wr_en_c),
        .wr_idx_c   (wr_idx_c),
        .clear_c    (clear_c)
    );

    // Contents are kept after handoff so downstream can sample on the handshake edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NUM_ELEM; k++) begin
                mat_q[k] <= '0;
            end
        end else if (wr_en_c) begin
            mat_q[wr_idx_c] <= s.in_data;
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            localparam int unsigned K = 32'(elem_idx(CNT_W'(r), CNT_W'(c)));
            assign s.mat_data[K*DATA_W +: DATA_W] = mat_q[K];
        end
    end

`ifdef DIAG_ZERO_CHECK_EN
    logic diag_q, diag_d;

    // Sticky until the matrix leaves (handoff) or is aborted (flush).
    always_comb begin
        diag_d = diag_q;
        if (clear_c) begin
            diag_d = 1'b0;
        end else if (wr_en_c && is_diag(wr_idx_c) && (s.in_data == '0)) begin
            diag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            diag_q <= 1'b0;
        end else begin
            diag_q <= diag_d;
        end
    end

    assign diag_zero = diag_q;
`else
    logic clear_unused;
    assign clear_unused = clear_c;
`endif

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Self-checking bench for matrix_stream_loader; diagonal screen tested when
// DIAG_ZERO_CHECK_EN is defined.
module tb_matrix_stream_loader;
    import matrix_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [CNT_W-1:0] load_count;
`ifdef DIAG_ZERO_CHECK_EN
    logic             diag_zero;
`endif

    matrix_stream_loader_if bus ();

    matrix_stream_loader dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .s          (bus),
        .load_count (load_count)
`ifdef DIAG_ZERO_CHECK_EN
        ,
        .diag_zero  (diag_zero)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the matrix is simply the list of accepted values in order.
    logic [DATA_W-1:0] exp_mat [NUM_ELEM];
    int                exp_cnt;

    function automatic logic [MAT_W-1:0] model_mat();
        logic [MAT_W-1:0] m;
        m = '0;
        for (int k = 0; k < int'(NUM_ELEM); k++) m[k*DATA_W +: DATA_W] = exp_mat[k];
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one element after a random idle gap; mat_ready toggles randomly
    // while loading, which the loader must ignore.
    task automatic send(input logic [DATA_W-1:0] v, input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        bus.in_valid = 1'b0;
        repeat (g) begin
            bus.mat_ready = 1'($urandom_range(1, 0));
            bus.in_data   = DATA_W'($urandom);
            tick();
        end
        bus.mat_ready = 1'($urandom_range(1, 0));
        bus.in_data   = v;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.mat_ready = 1'b0;
        exp_mat[exp_cnt] = v;
        exp_cnt++;
    endtask

    task automatic handoff();
        bus.mat_ready = 1'b1;
        tick();
        bus.mat_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.mat_ready = 1'b0;
        tick(); tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.mat_valid !== 1'b0) begin errors++; $display("FAIL reset_mat_valid got %b want 0", bus.mat_valid); end
        checks++; if (load_count !== '0) begin errors++; $display("FAIL reset_load_count got %0d want 0", load_count); end
        checks++; if (bus.mat_data !== '0) begin errors++; $display("FAIL reset_mat_data got %h want 0", bus.mat_data); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_sequential();
        exp_cnt = 0;
        for (int i = 0; i < int'(NUM_ELEM); i++) begin
            bus.in_data = DATA_W'(i + 1); bus.in_valid = 1'b1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL seq_in_ready i=%0d got %b want 1", i, bus.in_ready); end
            checks++; if (bus.mat_valid !== 1'b0) begin errors++; $display("FAIL seq_early_valid i=%0d got %b want 0", i, bus.mat_valid); end
            checks++; if (int'(load_count) != i) begin errors++; $display("FAIL seq_count i=%0d got %0d want %0d", i, load_count, i); end
            tick();
            exp_mat[exp_cnt] = DATA_W'(i + 1); exp_cnt++;
        end
        checks++; if (bus.mat_valid !== 1'b1) begin errors++; $display("FAIL seq_mat_valid got %b want 1", bus.mat_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL seq_full_in_ready got %b want 0", bus.in_ready); end
        checks++; if (int'(load_count) != 25) begin errors++; $display("FAIL seq_full_count got %0d want 25", load_count); end
        checks++; if (bus.mat_data !== model_mat()) begin errors++; $display("FAIL seq_mat_data got %h want %h", bus.mat_data, model_mat()); end
        bus.in_valid = 1'b0;
        handoff();
        checks++; if (bus.in_ready !== 1'b1 || bus.mat_valid !== 1'b0 || load_count !== '0) begin
            errors++; $display("FAIL seq_handoff got rdy=%b vld=%b cnt=%0d want 1 0 0", bus.in_ready, bus.mat_valid, load_count); end
        checks++; if (bus.mat_data !== model_mat()) begin errors++; $display("FAIL seq_retained got %h want %h", bus.mat_data, model_mat()); end
    endtask

    task automatic test_identity();
        exp_cnt = 0;
        for (int k = 0; k < int'(NUM_ELEM); k++) send(((k / int'(N)) == (k % int'(N))) ? 16'd1 : 16'd0, 3);
        for (int w = 0; w < 3; w++) begin
            checks++; if (bus.mat_valid !== 1'b1) begin errors++; $display("FAIL ident_hold w=%0d got %b want 1", w, bus.mat_valid); end
            tick();
        end
        checks++; if (bus.mat_data !== model_mat()) begin errors++; $display("FAIL ident_mat got %h want %h", bus.mat_data, model_mat()); end
        handoff();
        checks++; if (bus.mat_valid !== 1'b0 || bus.in_ready !== 1'b1 || load_count !== '0) begin
            errors++; $display("FAIL ident_handoff got vld=%b rdy=%b cnt=%0d want 0 1 0", bus.mat_valid, bus.in_ready, load_count); end
    endtask

    task automatic test_flush();
        exp_cnt = 0;
        for (int k = 0; k < 12; k++) send(DATA_W'($urandom), 2);
        checks++; if (int'(load_count) != 12) begin errors++; $display("FAIL flush_pre_count got %0d want 12", load_count); end
        flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'h1234;
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        checks++; if (load_count !== '0 || bus.in_ready !== 1'b1 || bus.mat_valid !== 1'b0) begin
            errors++; $display("FAIL flush_idle got cnt=%0d rdy=%b vld=%b want 0 1 0", load_count, bus.in_ready, bus.mat_valid); end
        exp_cnt = 0;
        for (int k = 0; k < int'(NUM_ELEM); k++) send(16'h00FF, 2);
        checks++; if (bus.mat_valid !== 1'b1 || bus.mat_data !== model_mat()) begin
            errors++; $display("FAIL flush_reload got vld=%b data=%h want 1 %h", bus.mat_valid, bus.mat_data, model_mat()); end
        // Flush with a simultaneous handshake in FULL: still an abort.
        flush = 1'b1; bus.mat_ready = 1'b1;
        tick();
        flush = 1'b0; bus.mat_ready = 1'b0;
        checks++; if (bus.mat_valid !== 1'b0 || load_count !== '0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_full got vld=%b cnt=%0d rdy=%b want 0 0 1", bus.mat_valid, load_count, bus.in_ready); end
    endtask

    task automatic test_async_reset();
        exp_cnt = 0;
        for (int k = 0; k < 7; k++) send(DATA_W'($urandom), 1);
        checks++; if (int'(load_count) != 7) begin errors++; $display("FAIL ares_pre_count got %0d want 7", load_count); end
        #2 reset = 1'b0;
        #1;
        checks++; if (load_count !== '0 || bus.in_ready !== 1'b1 || bus.mat_valid !== 1'b0 || bus.mat_data !== '0) begin
            errors++; $display("FAIL ares_load got cnt=%0d rdy=%b vld=%b data=%h want 0 1 0 0", load_count, bus.in_ready, bus.mat_valid, bus.mat_data); end
        tick(); reset = 1'b1; tick();
        exp_cnt = 0;
        for (int k = 0; k < int'(NUM_ELEM); k++) send(DATA_W'($urandom), 1);
        checks++; if (bus.mat_valid !== 1'b1) begin errors++; $display("FAIL ares_full_pre got %b want 1", bus.mat_valid); end
        #2 reset = 1'b0;
        #1;
        checks++; if (load_count !== '0 || bus.in_ready !== 1'b1 || bus.mat_valid !== 1'b0 || bus.mat_data !== '0) begin
            errors++; $display("FAIL ares_full got cnt=%0d rdy=%b vld=%b data=%h want 0 1 0 0", load_count, bus.in_ready, bus.mat_valid, bus.mat_data); end
        tick(); reset = 1'b1; tick();
        exp_cnt = 0;
        for (int k = 0; k < int'(NUM_ELEM); k++) send(DATA_W'($urandom), 2);
        checks++; if (bus.mat_valid !== 1'b1 || bus.mat_data !== model_mat()) begin
            errors++; $display("FAIL ares_recover got vld=%b data=%h want 1 %h", bus.mat_valid, bus.mat_data, model_mat()); end
        handoff();
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] v;
        exp_cnt = 0;
        for (int k = 0; k < int'(NUM_ELEM); k++) send(DATA_W'($urandom), 2);
        for (int w = 0; w < 10; w++) begin
            bus.in_valid = 1'b1; bus.in_data = 16'hDEAD;
            tick();
            checks++; if (int'(load_count) != 25 || bus.in_ready !== 1'b0 || bus.mat_valid !== 1'b1 || bus.mat_data !== model_mat()) begin
                errors++; $display("FAIL full_hold w=%0d got cnt=%0d rdy=%b vld=%b data=%h want 25 0 1 %h",
                                   w, load_count, bus.in_ready, bus.mat_valid, bus.mat_data, model_mat()); end
        end
        handoff();
        exp_cnt = 0;
        for (int i = 0; i < int'(NUM_ELEM); i++) begin
            v = DATA_W'($urandom);
            bus.in_valid = 1'b1; bus.in_data = v;
            checks++; if (bus.in_ready !== 1'b1 || bus.mat_valid !== 1'b0) begin
                errors++; $display("FAIL b2b_stream i=%0d got rdy=%b vld=%b want 1 0", i, bus.in_ready, bus.mat_valid); end
            tick();
            exp_mat[exp_cnt] = v; exp_cnt++;
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.mat_valid !== 1'b1 || int'(load_count) != 25 || bus.mat_data !== model_mat()) begin
            errors++; $display("FAIL b2b_full got vld=%b cnt=%0d data=%h want 1 25 %h", bus.mat_valid, load_count, bus.mat_data, model_mat()); end
        handoff();
    endtask

    task automatic test_random();
        int d;
        for (int m = 0; m < 3; m++) begin
            exp_cnt = 0;
            for (int k = 0; k < int'(NUM_ELEM); k++) send(DATA_W'($urandom), 4);
            d = int'($urandom_range(4, 0));
            repeat (d) tick();
            checks++; if (bus.mat_valid !== 1'b1 || bus.mat_data !== model_mat()) begin
                errors++; $display("FAIL rand_mat m=%0d got vld=%b data=%h want 1 %h", m, bus.mat_valid, bus.mat_data, model_mat()); end
            handoff();
            checks++; if (load_count !== '0 || bus.mat_valid !== 1'b0) begin
                errors++; $display("FAIL rand_handoff m=%0d got cnt=%0d vld=%b want 0 0", m, load_count, bus.mat_valid); end
        end
    endtask

`ifdef DIAG_ZERO_CHECK_EN
    task automatic test_diag_zero();
        logic [DATA_W-1:0] v;
        exp_cnt = 0;
        for (int k = 0; k < int'(NUM_ELEM); k++) send((k != 12 && (k / int'(N)) == (k % int'(N))) ? 16'd1 : 16'd0, 2);
        checks++; if (bus.mat_valid !== 1'b1 || diag_zero !== 1'b1) begin
            errors++; $display("FAIL diag_set got vld=%b diag=%b want 1 1", bus.mat_valid, diag_zero); end
        handoff();
        checks++; if (diag_zero !== 1'b0) begin errors++; $display("FAIL diag_clear got %b want 0", diag_zero); end
        exp_cnt = 0;
        for (int k = 0; k < int'(NUM_ELEM); k++) begin
            v = DATA_W'($urandom);
            if ((k / int'(N)) == (k % int'(N))) v = v | 16'h0001;
            else if (k % 3 == 0) v = '0;
            send(v, 2);
        end
        checks++; if (bus.mat_valid !== 1'b1 || diag_zero !== 1'b0) begin
            errors++; $display("FAIL diag_nonzero got vld=%b diag=%b want 1 0", bus.mat_valid, diag_zero); end
        handoff();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_identity();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
`ifdef DIAG_ZERO_CHECK_EN
        test_diag_zero();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
